// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use, branch-operand and MDU-busy stalls,
// taken-branch IF/ID flush, plus a saturating stall-cycle counter and the last stall cause.
module hazard_stall_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_mdu_read,
    input  logic             id_mdu_start,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regw,
    input  logic             ex_memr,
    input  logic             ex_mdu_start,
    input  logic [4:0]       mem_rd,
    input  logic             mem_memr,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       stall_cause
);

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_LOAD_USE  = 2'd1,
        CAUSE_BRANCH    = 2'd2,
        CAUSE_MDU       = 2'd3
    } cause_e;

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT);

    logic [3:0] mdu_cnt;
    logic [3:0] mdu_cnt_next;
    cause_e     cause_q;
    cause_e     cause_next;
    logic       busy;
    logic       ex_match;
    logic       mem_match;
    logic       lu;
    logic       br;
    logic       md;
    logic       stall;

    // $0 is hard-wired to zero, so a zero destination never creates a dependency.
    function automatic logic reg_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (dst != 5'd0) && (src == dst);
    endfunction

    assign busy      = (mdu_cnt != 4'd0);
    assign ex_match  = reg_match(id_uses_rs, id_rs, ex_rd) || reg_match(id_uses_rt, id_rt, ex_rd);
    assign mem_match = reg_match(id_uses_rs, id_rs, mem_rd) || reg_match(id_uses_rt, id_rt, mem_rd);

    assign lu    = ex_memr && ex_match;
    assign br    = id_is_branch && ((ex_regw && ex_match) || (mem_memr && mem_match));
    assign md    = busy && (id_mdu_read || id_mdu_start);
    assign stall = lu || br || md;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        mdu_busy    = 1'b0;
        if (!rst) begin
            mdu_busy = busy;
            if (stall) begin
                id_ex_stall = 1'b1;
            end else begin
                pc_wr       = 1'b1;
                if_id_wr    = 1'b1;
                if_id_flush = id_is_branch && id_branch_taken;
            end
        end
    end

    // A start while busy cannot come from a legal instruction stream; it is dropped.
    always_comb begin
        mdu_cnt_next = mdu_cnt;
        if (ex_mdu_start && !busy) begin
            mdu_cnt_next = MDU_LOAD;
        end else if (busy) begin
            mdu_cnt_next = mdu_cnt - 4'd1;
        end
    end

    always_comb begin
        cause_next = cause_q;
        if (lu) begin
            cause_next = CAUSE_LOAD_USE;
        end else if (br) begin
            cause_next = CAUSE_BRANCH;
        end else if (md) begin
            cause_next = CAUSE_MDU;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt      <= 4'd0;
            stall_cycles <= '0;
            cause_q      <= CAUSE_NONE;
        end else begin
            mdu_cnt <= mdu_cnt_next;
            if (stall) begin
                cause_q <= cause_next;
                if (stall_cycles != {CNT_W{1'b1}}) begin
                    stall_cycles <= stall_cycles + CNT_W'(1);
                end
            end
        end
    end

    assign stall_cause = cause_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default instance plus a CNT_W=4 instance for saturation.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken;
    logic        id_mdu_read, id_mdu_start, ex_regw, ex_memr, ex_mdu_start, mem_memr;
    logic        pc_wr, if_id_wr, if_id_flush, id_ex_stall, mdu_busy;
    logic [31:0] stall_cycles;
    logic [1:0]  stall_cause;
    logic        s_pc_wr, s_if_id_wr, s_if_id_flush, s_id_ex_stall, s_mdu_busy;
    logic [3:0]  s_stall_cycles;
    logic [1:0]  s_stall_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .id_mdu_read(id_mdu_read), .id_mdu_start(id_mdu_start),
        .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_mdu_start(ex_mdu_start),
        .mem_rd(mem_rd), .mem_memr(mem_memr),
        .pc_wr(pc_wr), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .stall_cause(stall_cause)
    );

    hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .id_mdu_read(id_mdu_read), .id_mdu_start(id_mdu_start),
        .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_mdu_start(ex_mdu_start),
        .mem_rd(mem_rd), .mem_memr(mem_memr),
        .pc_wr(s_pc_wr), .if_id_wr(s_if_id_wr), .if_id_flush(s_if_id_flush),
        .id_ex_stall(s_id_ex_stall), .mdu_busy(s_mdu_busy),
        .stall_cycles(s_stall_cycles), .stall_cause(s_stall_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0; id_branch_taken = 1'b0;
        id_mdu_read = 1'b0; id_mdu_start = 1'b0; ex_regw = 1'b0; ex_memr = 1'b0;
        ex_mdu_start = 1'b0; mem_memr = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input logic pw, input logic iw,
                              input logic fl, input logic st);
        check({tag, ".pc_wr"},       32'(pc_wr),       32'(pw));
        check({tag, ".if_id_wr"},    32'(if_id_wr),    32'(iw));
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(fl));
        check({tag, ".id_ex_stall"}, 32'(id_ex_stall), 32'(st));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        // Reset state, outputs forced low while rst=1.
        check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.mdu_busy", 32'(mdu_busy), 0);
        check("reset.stall_cycles", stall_cycles, 0);
        check("reset.stall_cause", 32'(stall_cause), 0);
        rst = 1'b0;
        #1;
        check_ctrl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use on rs.
        ex_memr = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        check_ctrl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("lu.stall_cycles", stall_cycles, 1);
        check("lu.stall_cause", 32'(stall_cause), 1);
        ex_memr = 1'b0;
        #1;
        check_ctrl("lu_release", 1'b1, 1'b1, 1'b0, 1'b0);

        // rt field matches but is not read: no hazard.
        clear_inputs();
        ex_memr = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1;
        check("unused_rt.id_ex_stall", 32'(id_ex_stall), 0);

        // $0 immunity.
        clear_inputs();
        ex_memr = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        check("zero_reg.pc_wr", 32'(pc_wr), 1);
        step();
        check("zero_reg.stall_cycles", stall_cycles, 1);

        // Branch operand produced by ALU op in EX: stall, no flush.
        clear_inputs();
        id_is_branch = 1'b1; id_branch_taken = 1'b1; ex_regw = 1'b1; ex_rd = 5'd5;
        id_rt = 5'd5; id_uses_rt = 1'b1;
        #1;
        check_ctrl("br_ex", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("br_ex.stall_cause", 32'(stall_cause), 2);
        check("br_ex.stall_cycles", stall_cycles, 2);
        ex_regw = 1'b0;
        #1;
        check_ctrl("br_taken", 1'b1, 1'b1, 1'b1, 1'b0);

        // Branch operand still loading in MEM.
        mem_memr = 1'b1; mem_rd = 5'd5;
        #1;
        check_ctrl("br_mem", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("br_mem.stall_cycles", stall_cycles, 3);
        // Same MEM load is harmless for a non-branch.
        id_is_branch = 1'b0; id_branch_taken = 1'b0;
        #1;
        check_ctrl("mem_nonbranch", 1'b1, 1'b1, 1'b0, 1'b0);
        // Not-taken branch without hazard does not flush.
        clear_inputs();
        id_is_branch = 1'b1;
        #1;
        check_ctrl("br_not_taken", 1'b1, 1'b1, 1'b0, 1'b0);

        // MDU: start at cycle 0, busy cycles 1..4, mfhi stalls until cycle 5.
        clear_inputs();
        ex_mdu_start = 1'b1;
        #1;
        check("mdu0.mdu_busy", 32'(mdu_busy), 0);
        step();
        ex_mdu_start = 1'b0; id_mdu_read = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("mdu%0d.mdu_busy", c), 32'(mdu_busy), 1);
            check($sformatf("mdu%0d.id_ex_stall", c), 32'(id_ex_stall), 1);
            step();
        end
        check("mdu5.mdu_busy", 32'(mdu_busy), 0);
        check_ctrl("mdu5", 1'b1, 1'b1, 1'b0, 1'b0);
        check("mdu5.stall_cause", 32'(stall_cause), 3);
        check("mdu5.stall_cycles", stall_cycles, 7);

        // Second start while busy is ignored: window still ends after cycle 4.
        clear_inputs();
        ex_mdu_start = 1'b1;
        step();
        step();
        ex_mdu_start = 1'b0;
        step();
        step();
        check("ign4.mdu_busy", 32'(mdu_busy), 1);
        step();
        check("ign5.mdu_busy", 32'(mdu_busy), 0);

        // Priority: load-use and MDU hazard together report load-use.
        ex_mdu_start = 1'b1;
        step();
        ex_mdu_start = 1'b0; id_mdu_read = 1'b1;
        ex_memr = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        step();
        check("prio.stall_cause", 32'(stall_cause), 1);
        check("prio.stall_cycles", stall_cycles, 8);

        // Reset at cycle 2 of the MDU window.
        clear_inputs();
        id_mdu_read = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_busy.mdu_busy", 32'(mdu_busy), 0);
        check_ctrl("rst_busy", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("rst_busy.stall_cycles", stall_cycles, 0);
        check("rst_busy.stall_cause", 32'(stall_cause), 0);
        rst = 1'b0;
        #1;
        check("post_rst.mdu_busy", 32'(mdu_busy), 0);
        check_ctrl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);

        // Saturation: 20 stalled edges on a 4-bit counter.
        clear_inputs();
        ex_memr = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        for (int c = 0; c < 14; c++) step();
        check("sat14.small", 32'(s_stall_cycles), 14);
        for (int c = 0; c < 6; c++) step();
        check("sat20.small", 32'(s_stall_cycles), 15);
        check("sat20.wide", stall_cycles, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
